// File: rtl/uart_result_tx_if.sv
// Handshake bundle between the inference core / host-side logic and the result UART transmitter.
interface uart_result_tx_if #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 32
) ();
  logic                           result_valid;
  logic                           result_ready;
  logic [3:0]                     result_class;
  logic [NUM_CLASSES*SCORE_W-1:0] result_scores;
  logic                           ack_valid;
  logic [7:0]                     ack_code;
  logic                           ack_dropped;
  logic                           tx;
  logic                           busy;
  logic                           frame_done;

  modport master (
    output result_valid, result_class, result_scores, ack_valid, ack_code,
    input  result_ready, ack_dropped, tx, busy, frame_done
  );

  modport slave (
    input  result_valid, result_class, result_scores, ack_valid, ack_code,
    output result_ready, ack_dropped, tx, busy, frame_done
  );
endinterface

// File: rtl/uart_result_tx.sv
// Result framer plus 8N1 serializer: sends DD 77 | class | scores | xor | 77 DD, and single ack bytes.
module uart_result_tx #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 32
) (
  input logic             clk,
  input logic             rst,
  uart_result_tx_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BPW          = SCORE_W / 8;
  localparam int NUM_BYTES    = NUM_CLASSES * BPW;
  localparam int IDX_W        = $clog2(NUM_BYTES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SOF1, S_SOF2, S_CLASS, S_SCORES, S_CSUM, S_EOF1, S_EOF2, S_ACK
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       csum_q, csum_d;
  logic [3:0]       class_q, class_d;
  logic [7:0]       sbuf_q [NUM_BYTES];
  logic [7:0]       sbuf_d [NUM_BYTES];
  logic             inflight_q, inflight_d;
  logic             ack_full_q, ack_full_d;
  logic [7:0]       ack_code_q, ack_code_d;
  logic             ack_dropped_q, ack_dropped_d;
  logic             tx_q, tx_d;
  logic             ser_busy_q, ser_busy_d;
  logic [8:0]       sh_q, sh_d;
  logic [3:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eof_q, eof_d;

  logic       capture, result_ready, stop_end, ser_ready, frame_done;
  logic       load, eof_load, ack_load;
  logic [7:0] load_byte;

  assign result_ready = (state_q == S_IDLE) && !inflight_q;
  assign capture      = bus.result_valid && result_ready;
  assign stop_end     = ser_busy_q && (bit_q == 4'd9) && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  // The next byte loads on the stop bit's final cycle, so bytes sit exactly 10 bit times apart.
  assign ser_ready    = !ser_busy_q || stop_end;
  assign frame_done   = stop_end && eof_q;

  // Score bytes are laid out in wire order at capture: class 0 first, each word MS byte first.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    class_d = class_q;
    sbuf_d  = sbuf_q;
    if (capture) begin
      class_d = bus.result_class;
      for (int i = 0; i < NUM_BYTES; i++) begin
        sbuf_d[i] = bus.result_scores[(i / BPW) * SCORE_W + (BPW - 1 - (i % BPW)) * 8 +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    load      = 1'b0;
    load_byte = 8'h00;
    eof_load  = 1'b0;
    ack_load  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (capture)         state_d = S_SOF1;
        else if (ack_full_q) state_d = S_ACK;
      end
      S_SOF1: if (ser_ready) begin
        load = 1'b1; load_byte = 8'hDD; state_d = S_SOF2;
      end
      S_SOF2: if (ser_ready) begin
        load = 1'b1; load_byte = 8'h77; state_d = S_CLASS;
      end
      S_CLASS: if (ser_ready) begin
        load = 1'b1; load_byte = {4'h0, class_q};
        csum_d = {4'h0, class_q};
        idx_d = '0; state_d = S_SCORES;
      end
      S_SCORES: if (ser_ready) begin
        load = 1'b1; load_byte = sbuf_q[idx_q];
        csum_d = csum_q ^ sbuf_q[idx_q];
        if (idx_q == IDX_W'(NUM_BYTES - 1)) state_d = S_CSUM;
        else                                idx_d   = idx_q + IDX_W'(1);
      end
      S_CSUM: if (ser_ready) begin
        load = 1'b1; load_byte = csum_q; state_d = S_EOF1;
      end
      S_EOF1: if (ser_ready) begin
        load = 1'b1; load_byte = 8'h77; state_d = S_EOF2;
      end
      S_EOF2: if (ser_ready) begin
        load = 1'b1; load_byte = 8'hDD; eof_load = 1'b1; state_d = S_IDLE;
      end
      S_ACK: if (ser_ready) begin
        load = 1'b1; load_byte = ack_code_q; ack_load = 1'b1; state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single-entry ack slot: a slot being drained this cycle may take a fresh ack.
  always_comb begin
    ack_full_d    = ack_full_q;
    ack_code_d    = ack_code_q;
    ack_dropped_d = 1'b0;
    inflight_d    = inflight_q;
    if (ack_load) ack_full_d = 1'b0;
    if (bus.ack_valid) begin
      if (!ack_full_q || ack_load) begin
        ack_full_d = 1'b1;
        ack_code_d = bus.ack_code;
      end else begin
        ack_dropped_d = 1'b1;
      end
    end
    if (capture)         inflight_d = 1'b1;
    else if (frame_done) inflight_d = 1'b0;
  end

  // Serializer: sh_q holds {stop, data}; tx_q already drives the bit being timed.
  always_comb begin
    ser_busy_d = ser_busy_q;
    sh_d       = sh_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    eof_d      = eof_q;
    if (ser_busy_q) begin
      if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
        cnt_d = '0;
        if (bit_q == 4'd9) begin
          ser_busy_d = 1'b0;
          tx_d       = 1'b1;
          eof_d      = 1'b0;
        end else begin
          tx_d  = sh_q[0];
          sh_d  = {1'b1, sh_q[8:1]};
          bit_d = bit_q + 4'd1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (load) begin
      ser_busy_d = 1'b1;
      tx_d       = 1'b0;
      sh_d       = {1'b1, load_byte};
      bit_d      = 4'd0;
      cnt_d      = '0;
      eof_d      = eof_load;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      csum_q        <= '0;
      inflight_q    <= 1'b0;
      ack_full_q    <= 1'b0;
      ack_code_q    <= '0;
      ack_dropped_q <= 1'b0;
      tx_q          <= 1'b1;
      ser_busy_q    <= 1'b0;
      sh_q          <= '1;
      bit_q         <= '0;
      cnt_q         <= '0;
      eof_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      csum_q        <= csum_d;
      inflight_q    <= inflight_d;
      ack_full_q    <= ack_full_d;
      ack_code_q    <= ack_code_d;
      ack_dropped_q <= ack_dropped_d;
      tx_q          <= tx_d;
      ser_busy_q    <= ser_busy_d;
      sh_q          <= sh_d;
      bit_q         <= bit_d;
      cnt_q         <= cnt_d;
      eof_q         <= eof_d;
    end
  end

  // NOTE: the capture buffer is left unreset; it is always written before it is read.
  always_ff @(posedge clk) begin
    class_q <= class_d;
    sbuf_q  <= sbuf_d;
  end

  assign bus.result_ready = result_ready;
  assign bus.ack_dropped  = ack_dropped_q;
  assign bus.tx           = tx_q;
  assign bus.busy         = (state_q != S_IDLE) || ser_busy_q || ack_full_q || inflight_q;
  assign bus.frame_done   = frame_done;

endmodule

// File: tb/tb_uart_result_tx.sv
// Randomized bench for uart_result_tx: a UART line monitor decodes tx and compares against a frame model.
module tb_uart_result_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 115_200;
  localparam int NC       = 10;
  localparam int SW       = 32;
  localparam int CLKS     = CLK_FREQ / BAUD;
  localparam int BYTE_T   = 10 * CLKS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_result_tx_if #(.NUM_CLASSES(NC), .SCORE_W(SW)) bus ();

  uart_result_tx #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .NUM_CLASSES(NC), .SCORE_W(SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fd_cnt   = 0;
  int drop_cnt = 0;
  int mon_err  = 0;

  logic [7:0] rx_q[$];
  int         rx_cyc[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1)  fd_cnt   <= fd_cnt + 1;
    if (bus.ack_dropped === 1'b1) drop_cnt <= drop_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line monitor: samples each bit mid-period, records the cycle where the start bit was first seen.
  initial begin : monitor
    logic [7:0] d;
    int         st;
    bit         bad;
    forever begin
      @(negedge clk);
      if (!rst && bus.tx === 1'b0) begin
        st  = cyc;
        bad = 1'b0;
        repeat (CLKS / 2) @(negedge clk);
        if (bus.tx !== 1'b0) bad = 1'b1;
        for (int j = 0; j < 8; j++) begin
          repeat (CLKS) @(negedge clk);
          d[j] = bus.tx;
        end
        repeat (CLKS) @(negedge clk);
        if (bus.tx !== 1'b1) bad = 1'b1;
        rx_q.push_back(d);
        rx_cyc.push_back(st);
        if (bad) mon_err++;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Reference frame: markers, class byte, scores word by word MS byte first, xor of payload, markers.
  task automatic build_frame(input logic [3:0] cls, input logic [NC*SW-1:0] sc);
    logic [7:0]    cs;
    logic [SW-1:0] w;
    exp_q.delete();
    exp_q.push_back(8'hDD);
    exp_q.push_back(8'h77);
    exp_q.push_back({4'h0, cls});
    cs = {4'h0, cls};
    for (int k = 0; k < NC; k++) begin
      w = sc[k*SW +: SW];
      for (int b = SW/8 - 1; b >= 0; b--) begin
        exp_q.push_back(w[b*8 +: 8]);
        cs = cs ^ w[b*8 +: 8];
      end
    end
    exp_q.push_back(cs);
    exp_q.push_back(8'h77);
    exp_q.push_back(8'hDD);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_cyc.delete();
    mon_err = 0;
  endtask

  task automatic compare_rx(input string tag);
    int n;
    int bad_gaps;
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    bad_gaps = 0;
    for (int i = 1; i < rx_cyc.size(); i++)
      if (rx_cyc[i] - rx_cyc[i-1] != BYTE_T) bad_gaps++;
    check({tag, "_byte_gaps"}, bad_gaps, 0);
    check({tag, "_framing"}, mon_err, 0);
  endtask

  task automatic random_scores(output logic [NC*SW-1:0] sc);
    for (int k = 0; k < NC; k++) sc[k*SW +: SW] = $urandom;
  endtask

  task automatic offer(input logic [3:0] cls, input logic [NC*SW-1:0] sc,
                       input bit with_ack, input logic [7:0] code, output int cap);
    int n;
    logic [NC*SW-1:0] junk;
    n = 0;
    @(negedge clk);
    while (bus.result_ready !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_offer", bus.result_ready, 1'b1);
    bus.result_valid  = 1'b1;
    bus.result_class  = cls;
    bus.result_scores = sc;
    bus.ack_valid     = with_ack;
    bus.ack_code      = code;
    cap = cyc;
    @(negedge clk);
    random_scores(junk);
    bus.result_valid  = 1'b0;
    bus.ack_valid     = 1'b0;
    bus.result_class  = 4'($urandom);
    bus.result_scores = junk;
  endtask

  task automatic wait_frame(input string tag);
    int n;
    int hi;
    bit seen;
    n = 0; hi = 0; seen = 1'b0;
    while (n < 60 * BYTE_T) begin
      @(negedge clk);
      n++;
      if (bus.frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.result_ready === 1'b1) hi++;
    end
    check({tag, "_frame_done_seen"}, seen, 1'b1);
    check({tag, "_ready_low_in_frame"}, hi, 0);
    @(negedge clk);
    check({tag, "_ready_after_done"}, bus.result_ready, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 3 * BYTE_T) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_clears"}, bus.busy, 1'b0);
    repeat (CLKS) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input logic [3:0] cls, input logic [NC*SW-1:0] sc);
    int cap;
    int fd0;
    clear_rx();
    fd0 = fd_cnt;
    offer(cls, sc, 1'b0, 8'h00, cap);
    wait_frame(tag);
    wait_idle(tag);
    build_frame(cls, sc);
    compare_rx(tag);
    check({tag, "_frame_done_once"}, fd_cnt - fd0, 1);
  endtask

  initial begin : stim
    logic [NC*SW-1:0] sc;
    int cap, fd0, drop0, n, bad, cnt;

    bus.result_valid  = 1'b0;
    bus.result_class  = '0;
    bus.result_scores = '0;
    bus.ack_valid     = 1'b0;
    bus.ack_code      = '0;

    // Reset values and a long quiet idle.
    repeat (4) @(negedge clk);
    check("rst_tx", bus.tx, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_frame_done", bus.frame_done, 1'b0);
    check("rst_ack_dropped", bus.ack_dropped, 1'b0);
    check("rst_ready", bus.result_ready, 1'b1);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.result_ready !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);
    check("idle_no_bytes", rx_q.size(), 0);

    // Ramp pattern, with start latency and known checksum.
    for (int k = 0; k < NC; k++) sc[k*SW +: SW] = k * 32'h0101_0101;
    clear_rx();
    fd0 = fd_cnt;
    offer(4'd7, sc, 1'b0, 8'h00, cap);
    wait_frame("ramp");
    wait_idle("ramp");
    build_frame(4'd7, sc);
    compare_rx("ramp");
    check("ramp_frame_done_once", fd_cnt - fd0, 1);
    if (rx_cyc.size() > 0) check("ramp_start_latency", rx_cyc[0] - cap, 2);
    if (rx_q.size() > 43) check("ramp_checksum", rx_q[43], 8'h07);

    // Marker-like payload bytes are sent verbatim.
    random_scores(sc);
    sc[SW-1:0] = 32'h77DD_77DD;
    run_frame("markers", 4'd2, sc);

    // Ack alongside a result follows EOF2 back-to-back; a second ack while full is dropped.
    random_scores(sc);
    clear_rx();
    fd0   = fd_cnt;
    drop0 = drop_cnt;
    offer(4'd5, sc, 1'b1, 8'hCC, cap);
    repeat (5 * BYTE_T) @(negedge clk);
    bus.ack_valid = 1'b1;
    bus.ack_code  = 8'hCD;
    @(negedge clk);
    bus.ack_valid = 1'b0;
    wait_frame("ack_pair");
    wait_idle("ack_pair");
    build_frame(4'd5, sc);
    exp_q.push_back(8'hCC);
    compare_rx("ack_pair");
    check("ack_pair_dropped_once", drop_cnt - drop0, 1);
    check("ack_pair_frame_done_once", fd_cnt - fd0, 1);

    // Ack on its own: one byte, no frame_done, exact busy window.
    clear_rx();
    fd0 = fd_cnt;
    @(negedge clk);
    bus.ack_valid = 1'b1;
    bus.ack_code  = 8'hCD;
    @(negedge clk);
    bus.ack_valid = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 3 * BYTE_T) begin
      cnt++;
      @(negedge clk);
    end
    check("ack_only_busy_cycles", cnt, BYTE_T + 2);
    repeat (2 * CLKS) @(negedge clk);
    exp_q.delete();
    exp_q.push_back(8'hCD);
    compare_rx("ack_only");
    check("ack_only_no_frame_done", fd_cnt - fd0, 0);

    // Reset in the middle of byte 20, with an ack parked in the slot.
    random_scores(sc);
    clear_rx();
    fd0 = fd_cnt;
    offer(4'($urandom_range(0, 15)), sc, 1'b0, 8'h00, cap);
    repeat (8 * BYTE_T) @(negedge clk);
    bus.ack_valid = 1'b1;
    bus.ack_code  = 8'h5A;
    @(negedge clk);
    bus.ack_valid = 1'b0;
    n = 0;
    while (rx_q.size() < 20 && n < 40 * BYTE_T) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached_byte20", rx_q.size() >= 20, 1'b1);
    repeat (3 * CLKS) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", bus.tx, 1'b1);
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_ready", bus.result_ready, 1'b1);
    rst = 1'b0;
    repeat (12 * CLKS) @(negedge clk);
    check("rst_mid_no_frame_done", fd_cnt - fd0, 0);
    clear_rx();
    repeat (12 * CLKS) @(negedge clk);
    check("rst_mid_silent_after", rx_q.size(), 0);
    check("rst_mid_idle_after", bus.busy, 1'b0);
    random_scores(sc);
    run_frame("after_rst", 4'($urandom_range(0, NC - 1)), sc);

    // Random frames, including out-of-range class values.
    for (int t = 0; t < 3; t++) begin
      random_scores(sc);
      run_frame($sformatf("rand%0d", t), 4'($urandom_range(0, 15)), sc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
